// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch: digit type, control states, digit limits.
package stopwatch_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned LIM_9   = 9;
    localparam int unsigned LIM_5   = 5;

    typedef logic [DIGIT_W-1:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    // Five fixed digits (s tens, s ones, ms x3) plus the minute digits
    function automatic int unsigned time_width(input int unsigned min_digits);
        return DIGIT_W * min_digits + 5 * DIGIT_W;
    endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// One BCD digit counting 0..LIMIT; carry fires when an increment wraps the digit.
module bcd_digit_cnt
    import stopwatch_pkg::*;
#(
    parameter int unsigned LIMIT = LIM_9
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_inc,
    input  logic i_clr,
    output bcd_t o_digit,
    output logic o_carry_c
);

    bcd_t r_digit;
    logic w_at_lim;

    assign w_at_lim = (r_digit == DIGIT_W'(LIMIT));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            r_digit <= '0;
        end else if (i_inc) begin
            r_digit <= w_at_lim ? '0 : r_digit + DIGIT_W'(1);
        end
    end

    assign o_digit   = r_digit;
    assign o_carry_c = i_inc && w_at_lim;

endmodule

// File: rtl/stopwatch_bcd_ctrl.sv
// Start/stop/clear stopwatch counting natively in BCD (min:s.ms) with sticky overflow.
// Lap capture is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_bcd_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 1000,
    parameter int unsigned MIN_DIGITS = 2
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic                                i_start,
    input  logic                                i_stop,
    input  logic                                i_clear,
    input  logic                                i_lap,
    output logic [time_width(MIN_DIGITS)-1:0]   o_bcd_time,
    output logic                                o_running,
    output logic                                o_overflow,
    output logic [time_width(MIN_DIGITS)-1:0]   o_lap_bcd,
    output logic                                o_lap_valid
);

    localparam int unsigned TW      = time_width(MIN_DIGITS);
    localparam int unsigned ND      = 5 + MIN_DIGITS;
    localparam int unsigned PRESC_W = 16;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_running;
    logic                 r_overflow;
    logic [PRESC_W-1:0]   r_presc;
    logic                 w_tick;
    logic                 w_top_carry;
    logic [TW-1:0]        w_time;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_running <= (w_state_nxt == RUN);
        end
    end

    // Priority: clear > stop > start
    always_comb begin
        w_state_nxt = r_state;
        if (i_clear) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (i_start) w_state_nxt = RUN;
                RUN:     if (i_stop)  w_state_nxt = PAUSE;
                PAUSE:   if (i_start) w_state_nxt = RUN;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign w_tick = (r_state == RUN) && (r_presc == PRESC_W'(CLK_DIV - 1));

    // Prescaler holds in PAUSE so the fractional millisecond survives a pause
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            r_presc <= '0;
        end else if (r_state == RUN) begin
            r_presc <= w_tick ? '0 : r_presc + PRESC_W'(1);
        end
    end

    // Digit 0 is ms ones; digit 4 (s tens) is the only one wrapping at 5
    for (genvar i = 0; i < ND; i++) begin : g_dig
        logic w_inc;
        logic w_carry;
        if (i == 0) begin : g_lsd
            assign w_inc = w_tick;
        end else begin : g_up
            assign w_inc = g_dig[i-1].w_carry;
        end
        bcd_digit_cnt #(
            .LIMIT ((i == 4) ? LIM_5 : LIM_9)
        ) u_cnt (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_inc     (w_inc),
            .i_clr     (i_clear),
            .o_digit   (w_time[DIGIT_W*i +: DIGIT_W]),
            .o_carry_c (w_carry)
        );
    end

    assign w_top_carry = g_dig[ND-1].w_carry;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            r_overflow <= 1'b0;
        end else if (w_top_carry) begin
            r_overflow <= 1'b1;
        end
    end

    assign o_bcd_time = w_time;
    assign o_running  = r_running;
    assign o_overflow = r_overflow;

`ifdef STOPWATCH_LAP_EN
    logic [TW-1:0] r_lap_bcd;
    logic          r_lap_valid;

    // Captures the digit registers before any coincident tick lands
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            r_lap_bcd   <= '0;
            r_lap_valid <= 1'b0;
        end else begin
            r_lap_valid <= 1'b0;
            if (i_lap && (r_state != IDLE)) begin
                r_lap_bcd   <= w_time;
                r_lap_valid <= 1'b1;
            end
        end
    end

    assign o_lap_bcd   = r_lap_bcd;
    assign o_lap_valid = r_lap_valid;
`else
    logic w_unused_lap;
    assign w_unused_lap = i_lap;
    assign o_lap_bcd    = '0;
    assign o_lap_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_bcd_ctrl.sv
// Directed bench for stopwatch_bcd_ctrl at CLK_DIV=4, MIN_DIGITS=2; honours STOPWATCH_LAP_EN.
module tb_stopwatch_bcd_ctrl;

    localparam int unsigned TW = 28;

    logic          i_clk;
    logic          i_rst_n;
    logic          i_start;
    logic          i_stop;
    logic          i_clear;
    logic          i_lap;
    logic [TW-1:0] o_bcd_time;
    logic          o_running;
    logic          o_overflow;
    logic [TW-1:0] o_lap_bcd;
    logic          o_lap_valid;

    int n_checks = 0;
    int n_errors = 0;

    stopwatch_bcd_ctrl #(
        .CLK_DIV    (4),
        .MIN_DIGITS (2)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_stop      (i_stop),
        .i_clear     (i_clear),
        .i_lap       (i_lap),
        .o_bcd_time  (o_bcd_time),
        .o_running   (o_running),
        .o_overflow  (o_overflow),
        .o_lap_bcd   (o_lap_bcd),
        .o_lap_valid (o_lap_valid)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and sample 1ns later
    task automatic cyc(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic pulse_start();
        i_start = 1'b1; cyc(1); i_start = 1'b0;
    endtask

    task automatic pulse_stop();
        i_stop = 1'b1; cyc(1); i_stop = 1'b0;
    endtask

    task automatic pulse_clear();
        i_clear = 1'b1; cyc(1); i_clear = 1'b0;
    endtask

    task automatic release_all();
        release dut.g_dig[3].u_cnt.r_digit;
        release dut.g_dig[4].u_cnt.r_digit;
        release dut.g_dig[5].u_cnt.r_digit;
        release dut.g_dig[6].u_cnt.r_digit;
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_stop  = 1'b0;
        i_clear = 1'b0;
        i_lap   = 1'b0;
        cyc(2);
        i_rst_n = 1'b1;
        cyc(1);
        chk("rst_time",    32'(o_bcd_time), 32'h0);
        chk("rst_running", 32'(o_running),  32'h0);
        chk("rst_ovf",     32'(o_overflow), 32'h0);
        chk("rst_lap",     32'(o_lap_bcd),  32'h0);
        chk("rst_lapv",    32'(o_lap_valid), 32'h0);

        // reset mid-run
        pulse_start();
        cyc(10);
        chk("prerst_time", 32'(o_bcd_time), 32'h2);
        i_rst_n = 1'b0;
        cyc(2);
        chk("midrst_time",    32'(o_bcd_time), 32'h0);
        chk("midrst_running", 32'(o_running),  32'h0);
        i_rst_n = 1'b1;

        // first tick exactly 4 cycles after start
        pulse_start();
        chk("start_running", 32'(o_running), 32'h1);
        cyc(3);
        chk("no_tick_yet", 32'(o_bcd_time), 32'h0);
        cyc(1);
        chk("first_tick", 32'(o_bcd_time), 32'h1);

        // 40 cycles -> 10 ms
        pulse_clear();
        chk("clr_time",    32'(o_bcd_time), 32'h0);
        chk("clr_running", 32'(o_running),  32'h0);
        pulse_start();
        cyc(40);
        chk("run40_time",    32'(o_bcd_time), 32'h10);
        chk("run40_running", 32'(o_running),  32'h1);

        // pause 2 cycles after a tick, fractional ms preserved
        cyc(1);
        pulse_stop();
        chk("pause_running", 32'(o_running),  32'h0);
        chk("pause_time",    32'(o_bcd_time), 32'h10);
        cyc(100);
        chk("pause_hold", 32'(o_bcd_time), 32'h10);
        pulse_start();
        chk("resume_running", 32'(o_running),  32'h1);
        cyc(1);
        chk("resume_c1", 32'(o_bcd_time), 32'h10);
        cyc(1);
        chk("resume_c2", 32'(o_bcd_time), 32'h11);

        // stop on a tick cycle still applies the tick
        cyc(3);
        pulse_stop();
        chk("stop_tick_time",    32'(o_bcd_time), 32'h12);
        chk("stop_tick_running", 32'(o_running),  32'h0);
        pulse_clear();
        chk("clr2_time", 32'(o_bcd_time), 32'h0);

        // seconds to minute carry: xx:59.999 -> 01:00.000
        force dut.g_dig[4].u_cnt.r_digit = 4'd5;
        force dut.g_dig[3].u_cnt.r_digit = 4'd9;
        pulse_start();
        cyc(3999);
        chk("s59_999", 32'({o_bcd_time[27:20], o_bcd_time[11:0]}), 32'h00999);
        cyc(1);
        chk("min_carry", 32'({o_bcd_time[27:20], o_bcd_time[11:0]}), 32'h01000);
        pulse_clear();
        release_all();
        pulse_clear();
        chk("clr3_time", 32'(o_bcd_time), 32'h0);

        // 09:59.999 -> 10:00.000
        force dut.g_dig[5].u_cnt.r_digit = 4'd9;
        force dut.g_dig[4].u_cnt.r_digit = 4'd5;
        force dut.g_dig[3].u_cnt.r_digit = 4'd9;
        pulse_start();
        cyc(3999);
        chk("m9_999", 32'({o_bcd_time[27:24], o_bcd_time[11:0]}), 32'h0999);
        cyc(1);
        chk("mtens_carry", 32'({o_bcd_time[27:24], o_bcd_time[11:0]}), 32'h1000);
        pulse_clear();
        release_all();
        pulse_clear();
        chk("clr4_time", 32'(o_bcd_time), 32'h0);

        // 99:59.999 + tick -> overflow, sticky, counting continues
        force dut.g_dig[6].u_cnt.r_digit = 4'd9;
        force dut.g_dig[5].u_cnt.r_digit = 4'd9;
        force dut.g_dig[4].u_cnt.r_digit = 4'd5;
        force dut.g_dig[3].u_cnt.r_digit = 4'd9;
        pulse_start();
        cyc(3999);
        chk("pre_ovf",    32'(o_overflow), 32'h0);
        chk("pre_ovf_ms", 32'(o_bcd_time[11:0]), 32'h999);
        cyc(1);
        chk("ovf_set",    32'(o_overflow), 32'h1);
        chk("ovf_ms",     32'(o_bcd_time[11:0]), 32'h000);
        cyc(4);
        chk("ovf_sticky", 32'(o_overflow), 32'h1);
        chk("ovf_count",  32'(o_bcd_time[11:0]), 32'h001);
        pulse_clear();
        chk("ovf_clr",         32'(o_overflow), 32'h0);
        chk("ovf_clr_running", 32'(o_running),  32'h0);
        release_all();
        pulse_clear();
        chk("clr5_time", 32'(o_bcd_time), 32'h0);
        chk("unforced_wrap", 32'(o_overflow), 32'h0);

        // lap on the tick cycle at 00:01.234
        pulse_start();
        cyc(4939);
        chk("lap_pre_time", 32'(o_bcd_time), 32'h0001234);
        i_lap = 1'b1;
        cyc(1);
        i_lap = 1'b0;
        chk("lap_time", 32'(o_bcd_time), 32'h0001235);
`ifdef STOPWATCH_LAP_EN
        chk("lap_bcd",   32'(o_lap_bcd),   32'h0001234);
        chk("lap_valid", 32'(o_lap_valid), 32'h1);
        cyc(1);
        chk("lap_valid_drop", 32'(o_lap_valid), 32'h0);
        pulse_clear();
        chk("lap_clr", 32'(o_lap_bcd), 32'h0);
        i_lap = 1'b1;
        cyc(1);
        i_lap = 1'b0;
        chk("lap_idle_ignored", 32'(o_lap_valid), 32'h0);
`else
        chk("lap_bcd_off",   32'(o_lap_bcd),   32'h0);
        chk("lap_valid_off", 32'(o_lap_valid), 32'h0);
        cyc(1);
        chk("lap_valid_off2", 32'(o_lap_valid), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
